// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a shared synchronous-read memory.
// Writes complete in the grant cycle; reads hold the bus until data returns.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int READ_LATENCY   = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_funct3,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_funct3,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_funct3;
    logic                r_m0_rvalid;
    logic                r_m1_rvalid;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_grant;
    logic                w_win;
    logic                w_we;
    logic [2:0]          w_funct3;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        w_grant = rst_n && (r_state == IDLE) && (m0_req || m1_req);
        if (m0_req && m1_req)
            w_win = (FIXED_PRIORITY != 0) ? 1'b0 : ~r_last;
        else
            w_win = m1_req;
        w_we     = w_win ? m1_we     : m0_we;
        w_funct3 = w_win ? m1_funct3 : m0_funct3;
        w_addr   = w_win ? m1_addr   : m0_addr;
        w_wdata  = w_win ? m1_wdata  : m0_wdata;
    end

    assign m0_gnt     = w_grant & ~w_win;
    assign m1_gnt     = w_grant &  w_win;
    assign mem_write  = w_grant & w_we;
    assign mem_addr   = w_grant ? w_addr   : r_addr;
    assign mem_funct3 = w_grant ? w_funct3 : r_funct3;
    assign mem_wdata  = w_wdata;

    assign m0_rvalid  = r_m0_rvalid;
    assign m1_rvalid  = r_m1_rvalid;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_funct3    <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_last <= w_win;
                        if (!w_we) begin
                            r_owner  <= w_win;
                            r_addr   <= w_addr;
                            r_funct3 <= w_funct3;
                            r_cnt    <= CNT_W'(READ_LATENCY - 1);
                            r_state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Only the owner's data register is updated; the other holds.
                        if (r_owner) begin
                            r_m1_rdata  <= mem_rdata;
                            r_m1_rvalid <= 1'b1;
                        end else begin
                            r_m0_rdata  <= mem_rdata;
                            r_m0_rvalid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 round-robin, latency 3 fixed
// priority) run against a transaction-level model and a simple memory.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b1;
    always #5 clk = ~clk;

    logic        req[2][2];
    logic        we[2][2];
    logic [2:0]  f3[2][2];
    logic [31:0] addr[2][2];
    logic [31:0] wdata[2][2];
    logic        gnt[2][2];
    logic        rv[2][2];
    logic [31:0] rd[2][2];
    logic        mw[2];
    logic [2:0]  mf3[2];
    logic [31:0] maddr[2];
    logic [31:0] mwd[2];
    logic [31:0] mrd[2];

    logic [31:0] tmem[2][64];
    logic [31:0] pipe[2][3];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .FIXED_PRIORITY(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_funct3(f3[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_funct3(f3[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m0_gnt(gnt[0][0]), .m1_gnt(gnt[0][1]), .m0_rvalid(rv[0][0]), .m1_rvalid(rv[0][1]),
        .m0_rdata(rd[0][0]), .m1_rdata(rd[0][1]),
        .mem_write(mw[0]), .mem_funct3(mf3[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .FIXED_PRIORITY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_funct3(f3[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_funct3(f3[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m0_gnt(gnt[1][0]), .m1_gnt(gnt[1][1]), .m0_rvalid(rv[1][0]), .m1_rvalid(rv[1][1]),
        .m0_rdata(rd[1][0]), .m1_rdata(rd[1][1]),
        .mem_write(mw[1]), .mem_funct3(mf3[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    // Synchronous-read memory per instance; read data emerges after 1 or 3 edges.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load) begin
                for (int k = 0; k < 64; k++) tmem[i][k] <= 32'hA5A5_0000 | k;
            end else if (mw[i]) begin
                tmem[i][maddr[i][7:2]] <= mwd[i];
            end
            pipe[i][0] <= tmem[i][maddr[i][7:2]];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end
    assign mrd[0] = pipe[0][0];
    assign mrd[1] = pipe[1][2];

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          lat[2] = '{1, 3};
    bit          fp[2]  = '{1'b0, 1'b1};
    logic [31:0] mmem[2][64];
    int          free_at[2];
    bit          mlast[2];
    bit          pend[2];
    int          rcyc[2];
    bit          rown[2];
    logic [31:0] rdat[2];
    logic [31:0] lat_a[2];
    logic [2:0]  lat_f[2];
    logic [31:0] erd[2][2];
    bit          mg[2][2];

    logic        s_gnt[2][2];
    logic        s_rv[2][2];
    logic [31:0] s_rd[2][2];
    logic        s_mw[2];
    logic [31:0] s_ma[2];
    logic [31:0] s_mwd[2];
    logic [2:0]  s_mf[2];

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset(int i);
        free_at[i] = 0;
        mlast[i]   = 1'b1;
        pend[i]    = 1'b0;
        lat_a[i]   = '0;
        lat_f[i]   = '0;
        erd[i][0]  = '0;
        erd[i][1]  = '0;
        mg[i][0]   = 1'b0;
        mg[i][1]   = 1'b0;
    endfunction

    // One clock cycle: predict from the model, compare at the falling edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit          eg[2];
            bit          erv[2];
            bit          emw;
            bit          w;
            logic [31:0] ea;
            logic [2:0]  ef;
            eg = '{1'b0, 1'b0};
            erv = '{1'b0, 1'b0};
            emw = 1'b0;
            w = 1'b0;
            ea = lat_a[i];
            ef = lat_f[i];
            if (!rst_n) begin
                model_reset(i);
                ea = '0;
                ef = '0;
            end else begin
                if (pend[i] && rcyc[i] == cyc) begin
                    erv[rown[i]] = 1'b1;
                    erd[i][rown[i]] = rdat[i];
                    pend[i] = 1'b0;
                end
                if (cyc >= free_at[i] && (req[i][0] || req[i][1])) begin
                    if (req[i][0] && req[i][1]) w = fp[i] ? 1'b0 : ~mlast[i];
                    else w = req[i][1];
                    eg[w] = 1'b1;
                    mlast[i] = w;
                    ea = addr[i][w];
                    ef = f3[i][w];
                    chk("mem_wdata", i, mwd[i], wdata[i][w]);
                    if (we[i][w]) begin
                        emw = 1'b1;
                        mmem[i][addr[i][w][7:2]] = wdata[i][w];
                    end else begin
                        pend[i]    = 1'b1;
                        rcyc[i]    = cyc + 1 + lat[i];
                        free_at[i] = cyc + 1 + lat[i];
                        rown[i]    = w;
                        rdat[i]    = mmem[i][addr[i][w][7:2]];
                        lat_a[i]   = addr[i][w];
                        lat_f[i]   = f3[i][w];
                    end
                end
            end
            mg[i][0] = eg[0];
            mg[i][1] = eg[1];
            chk("m0_gnt", i, gnt[i][0], eg[0]);
            chk("m1_gnt", i, gnt[i][1], eg[1]);
            chk("m0_rvalid", i, rv[i][0], erv[0]);
            chk("m1_rvalid", i, rv[i][1], erv[1]);
            chk("m0_rdata", i, rd[i][0], erd[i][0]);
            chk("m1_rdata", i, rd[i][1], erd[i][1]);
            chk("mem_write", i, mw[i], emw);
            chk("mem_addr", i, maddr[i], ea);
            chk("mem_funct3", i, mf3[i], ef);
            for (int r = 0; r < 2; r++) begin
                s_gnt[i][r] = gnt[i][r];
                s_rv[i][r]  = rv[i][r];
                s_rd[i][r]  = rd[i][r];
            end
            s_mw[i]  = mw[i];
            s_ma[i]  = maddr[i];
            s_mwd[i] = mwd[i];
            s_mf[i]  = mf3[i];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(int r, logic q, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            req[i][r] = q; we[i][r] = w; f3[i][r] = f; addr[i][r] = a; wdata[i][r] = d;
        end
    endtask

    task automatic drive_rand();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (mg[i][r] || !req[i][r]) begin
                    if ($urandom_range(99) < 40) begin
                        req[i][r]   = 1'b1;
                        we[i][r]    = 1'($urandom_range(1));
                        f3[i][r]    = 3'($urandom_range(7));
                        addr[i][r]  = 32'($urandom_range(255));
                        wdata[i][r] = $urandom;
                    end else begin
                        req[i][r] = 1'b0;
                    end
                end else if ($urandom_range(99) < 4) begin
                    req[i][r] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) mmem[i][k] = 32'hA5A5_0000 | k;
            model_reset(i);
        end
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_m0_gnt", i, s_gnt[i][0], 1'b0);
            chk("rst_m1_rvalid", i, s_rv[i][1], 1'b0);
            chk("rst_mem_write", i, s_mw[i], 1'b0);
            chk("rst_mem_addr", i, s_ma[i], 32'h0);
        end
        rst_n = 1'b1;

        // m0 read of 0x10
        set_req(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        step();
        for (int i = 0; i < 2; i++) chk("rd10_gnt", i, s_gnt[i][0], 1'b1);
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();
        chk("rd10_rvalid_l1", 0, s_rv[0][0], 1'b1);
        chk("rd10_rdata_l1", 0, s_rd[0][0], 32'hA5A5_0004);
        chk("rd10_early_l3", 1, s_rv[1][0], 1'b0);
        step();
        chk("rd10_hold_addr_l3", 1, s_ma[1], 32'h10);
        step();
        chk("rd10_rvalid_l3", 1, s_rv[1][0], 1'b1);
        chk("rd10_rdata_l3", 1, s_rd[1][0], 32'hA5A5_0004);

        // m1 write then read back of 0x20
        set_req(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("wr20_gnt", i, s_gnt[i][1], 1'b1);
            chk("wr20_mem_write", i, s_mw[i], 1'b1);
            chk("wr20_addr", i, s_ma[i], 32'h20);
            chk("wr20_wdata", i, s_mwd[i], 32'hDEAD_BEEF);
            chk("wr20_funct3", i, s_mf[i], 3'b010);
        end
        set_req(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        step();
        set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        chk("wr20_mem_write_drop", 0, s_mw[0], 1'b0);
        step();
        chk("rd20_rdata_l1", 0, s_rd[0][1], 32'hDEAD_BEEF);
        step();
        step();
        chk("rd20_rdata_l3", 1, s_rd[1][1], 32'hDEAD_BEEF);
        chk("rd20_m0_rdata_held", 1, s_rd[1][0], 32'hA5A5_0004);

        // both requesters writing every cycle
        set_req(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h0000_0001);
        set_req(1, 1'b1, 1'b1, 3'b010, 32'h44, 32'h0000_0002);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_m0_gnt", 0, s_gnt[0][0], (k % 2) == 0);
            chk("alt_m1_gnt", 0, s_gnt[0][1], (k % 2) == 1);
            chk("fix_m0_gnt", 1, s_gnt[1][0], 1'b1);
            chk("fix_m1_gnt", 1, s_gnt[1][1], 1'b0);
        end
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // m1 write arrives while m0 read is outstanding
        set_req(0, 1'b1, 1'b0, 3'b000, 32'h30, 32'h0);
        step();
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b1, 3'b001, 32'h34, 32'hCAFE_0001);
        step();
        for (int i = 0; i < 2; i++) chk("wait_m1_gnt", i, s_gnt[i][1], 1'b0);
        step();
        chk("wait_end_rvalid", 0, s_rv[0][0], 1'b1);
        chk("wait_end_m1_gnt", 0, s_gnt[0][1], 1'b1);
        chk("wait_end_m1_rvalid", 0, s_rv[0][1], 1'b0);
        step();
        step();
        chk("wait_end_rvalid", 1, s_rv[1][0], 1'b1);
        chk("wait_end_m1_gnt", 1, s_gnt[1][1], 1'b1);
        chk("wait_end_m1_rvalid", 1, s_rv[1][1], 1'b0);
        set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();

        // reset while both instances are waiting on a read
        set_req(0, 1'b1, 1'b0, 3'b000, 32'h08, 32'h0);
        step();
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            for (int i = 0; i < 2; i++) chk("post_rst_rvalid", i, s_rv[i][0], 1'b0);
        end
        set_req(1, 1'b1, 1'b1, 3'b000, 32'h0C, 32'h1234_5678);
        step();
        for (int i = 0; i < 2; i++) chk("post_rst_gnt", i, s_gnt[i][1], 1'b1);
        set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();

        repeat (2000) begin
            drive_rand();
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
